// File: rtl/pdu_dbg.sv
// Debug/peripheral unit: CPU clock generator (run/step/burst/breakpoint),
// probe viewer, memory-mapped I/O registers and scanned 7-segment output.
//
// Ports:
//   clk, rst          system clock, async active-high reset
//   run, step, valid  raw board switch/buttons
//   in                raw switches; in[0]=next, in[1]=prev (any edge)
//   clk_cpu           generated CPU clock
//   pc                CPU fetch PC for breakpoint compare
//   io_addr/dout/we   CPU I/O write bus; io_din is combinational read data
//   probe             NCH flattened probe channels of DW bits
//   out0, ready       LED field and ready LED
//   halted, view      breakpoint-hit LED, viewer mode
//   an, seg           display digit select and nibble
module pdu_dbg #(
  parameter int DW        = 32,
  parameter int NCH       = 16,
  parameter int CW        = 5,
  parameter int SCAN_BITS = 20,
  localparam int SW       = $clog2(NCH),
  localparam int AW       = (DW > 4) ? $clog2(DW / 4) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              valid,
  input  logic [CW-1:0]     in,
  output logic              clk_cpu,
  input  logic [DW-1:0]     pc,
  input  logic [7:0]        io_addr,
  input  logic [DW-1:0]     io_dout,
  input  logic              io_we,
  output logic [DW-1:0]     io_din,
  input  logic [NCH*DW-1:0] probe,
  output logic [CW-1:0]     out0,
  output logic              ready,
  output logic              halted,
  output logic              view,
  output logic [AW-1:0]     an,
  output logic [3:0]        seg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2,
    HALT  = 2'd3
  } st_t;

  // ---------------- input conditioning ----------------
  logic [1:0]    run_q;
  logic [2:0]    step_q;
  logic [2:0]    valid_q;
  logic [CW-1:0] in1_q, in2_q;
  logic [1:0]    in3_q;
  logic          step_p_q, valid_p_q, nx_q, pv_q;
  logic          run_s;

  assign run_s = run_q[1];

  // Edge pulses are registered so the FSM sees a clean one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q     <= '0;
      step_q    <= '0;
      valid_q   <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      in3_q     <= '0;
      step_p_q  <= 1'b0;
      valid_p_q <= 1'b0;
      nx_q      <= 1'b0;
      pv_q      <= 1'b0;
    end else begin
      run_q     <= {run_q[0], run};
      step_q    <= {step_q[1:0], step};
      valid_q   <= {valid_q[1:0], valid};
      in1_q     <= in;
      in2_q     <= in1_q;
      in3_q     <= in2_q[1:0];
      step_p_q  <= step_q[1] & ~step_q[2];
      valid_p_q <= valid_q[1] & ~valid_q[2];
      nx_q      <= in2_q[0] ^ in3_q[0];
      pv_q      <= in2_q[1] ^ in3_q[1];
    end
  end

  // ---------------- I/O registers ----------------
  logic [CW-1:0] out0_q;
  logic          ready_q;
  logic [DW-1:0] out1_q;
  logic [DW-1:0] bp_addr_q;
  logic          bp_en_q;
  logic [15:0]   burst_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_q    <= '1;
      ready_q   <= 1'b1;
      out1_q    <= DW'(32'h1234_5678);
      bp_addr_q <= '0;
      bp_en_q   <= 1'b0;
      burst_n_q <= '0;
    end else if (io_we) begin
      unique case (io_addr)
        8'h00: out0_q  <= io_dout[CW-1:0];
        8'h04: ready_q <= io_dout[0];
        8'h08: out1_q  <= io_dout;
        8'h14: begin
          bp_addr_q <= io_dout;
          bp_en_q   <= 1'b1;
        end
        8'h18: burst_n_q <= io_dout[15:0];
        8'h1C: bp_en_q   <= io_dout[0];
        default: ;
      endcase
    end
  end

  // ---------------- clock FSM ----------------
  st_t         state_q;
  logic        clk_cpu_q;
  logic        halted_q;
  logic        first_q;
  logic [15:0] rem_q;
  logic        bp_hit;

  // first_q masks the compare until the first rising edge after a
  // (re)start, so resuming from a breakpoint PC makes progress.
  assign bp_hit = bp_en_q && !first_q && (pc == bp_addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cpu_q <= 1'b0;
      halted_q  <= 1'b0;
      first_q   <= 1'b0;
      rem_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          clk_cpu_q <= 1'b0;
          if (run_s) begin
            state_q <= RUN;
            first_q <= 1'b1;
          end else if (step_p_q) begin
            if (burst_n_q == '0) begin
              clk_cpu_q <= 1'b1;
            end else begin
              rem_q   <= burst_n_q;
              state_q <= BURST;
              first_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (clk_cpu_q) begin
            clk_cpu_q <= 1'b0;
          end else if (!run_s) begin
            state_q <= IDLE;
          end else if (bp_hit) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            clk_cpu_q <= 1'b1;
            first_q   <= 1'b0;
          end
        end
        BURST: begin
          if (clk_cpu_q) begin
            clk_cpu_q <= 1'b0;
          end else if (rem_q == '0) begin
            state_q <= IDLE;
          end else if (bp_hit) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            clk_cpu_q <= 1'b1;
            rem_q     <= rem_q - 16'd1;
            first_q   <= 1'b0;
          end
        end
        HALT: begin
          if (!run_s) begin
            state_q   <= IDLE;
            halted_q  <= 1'b0;
            clk_cpu_q <= 1'b0;
          end else begin
            clk_cpu_q <= step_p_q & ~clk_cpu_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- viewer ----------------
  logic          view_q;
  logic [SW-1:0] sel_q, sel_d;
  logic [SCAN_BITS-1:0] cnt_q;

  always_comb begin
    sel_d = sel_q;
    if (nx_q && !pv_q) begin
      sel_d = (sel_q == SW'(NCH - 1)) ? '0 : sel_q + 1'b1;
    end else if (pv_q && !nx_q) begin
      sel_d = (sel_q == '0) ? SW'(NCH - 1) : sel_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      view_q <= 1'b0;
      sel_q  <= '0;
      cnt_q  <= '0;
    end else begin
      view_q <= view_q ^ valid_p_q;
      sel_q  <= sel_d;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // ---------------- display ----------------
  logic [CW-1:0]         sel_x;
  logic [DW-1:0]         disp;
  logic [4*(2**AW)-1:0]  disp_x;

  always_comb begin
    sel_x          = '0;
    sel_x[SW-1:0]  = sel_q;
    disp           = view_q ? probe[int'(sel_q)*DW +: DW] : out1_q;
    disp_x         = '0;
    disp_x[DW-1:0] = disp;
  end

  assign an  = cnt_q[SCAN_BITS-1 -: AW];
  assign seg = disp_x[4*int'(an) +: 4];

  // ---------------- read mux ----------------
  always_comb begin
    io_din = '0;
    unique case (io_addr)
      8'h0C: io_din[CW-1:0] = in2_q;
      8'h10: io_din[0]      = valid_q[1];
      8'h14: io_din         = bp_addr_q;
      8'h18: io_din[15:0]   = burst_n_q;
      8'h1C: io_din[3:0]    = {halted_q, state_q, bp_en_q};
      default: ;
    endcase
  end

  assign clk_cpu = clk_cpu_q;
  assign halted  = halted_q;
  assign view    = view_q;
  assign ready   = ready_q;
  assign out0    = view_q ? sel_x : out0_q;

endmodule

// File: tb/tb_pdu_dbg.sv
// Self-checking bench for pdu_dbg: register vectors, display scan,
// step/burst/breakpoint clocking, viewer wrap and mid-burst reset.
module tb_pdu_dbg;

  localparam int DW  = 32;
  localparam int NCH = 16;
  localparam int CW  = 5;
  localparam int SB  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0, step = 1'b0, valid = 1'b0;
  logic [CW-1:0]     in_v = '0;
  logic              clk_cpu;
  logic [DW-1:0]     pc_v = '0;
  logic [7:0]        io_addr = 8'hFF;
  logic [DW-1:0]     io_dout = '0;
  logic              io_we = 1'b0;
  logic [DW-1:0]     io_din;
  logic [NCH*DW-1:0] probe = '0;
  logic [CW-1:0]     out0;
  logic              ready, halted, view;
  logic [2:0]        an;
  logic [3:0]        seg;

  pdu_dbg #(.DW(DW), .NCH(NCH), .CW(CW), .SCAN_BITS(SB)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .valid(valid),
    .in(in_v), .clk_cpu(clk_cpu), .pc(pc_v), .io_addr(io_addr),
    .io_dout(io_dout), .io_we(io_we), .io_din(io_din),
    .probe(probe), .out0(out0), .ready(ready), .halted(halted),
    .view(view), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int edges = 0, hi_len = 0, max_hi = 0;
  bit pc_auto = 1'b0;

  always @(posedge clk_cpu) begin
    edges++;
    if (pc_auto) pc_v = pc_v + 32'd4;
  end

  always @(negedge clk) begin
    if (clk_cpu) hi_len++;
    else hi_len = 0;
    if (hi_len > max_hi) max_hi = hi_len;
  end

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [7:0]  ra;
    logic [31:0] rexp;
    logic [4:0]  o0;
    logic        rdy;
  } vec_t;
  vec_t vecs[15];

  logic [31:0] pv[NCH];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_cmp(input logic [31:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk(e.nm, act, e.v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a;
    io_dout = d;
    io_we   = 1'b1;
    tick();
    io_we   = 1'b0;
    io_addr = 8'hFF;
  endtask

  task automatic io_rd(input logic [7:0] a, output logic [31:0] d);
    io_addr = a;
    #1;
    d = io_din;
  endtask

  task automatic press_step();
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    repeat (6) tick();
  endtask

  task automatic chk_digits(input string nm, input logic [31:0] v);
    for (int i = 0; i < 8; i++) begin
      int n = 0;
      while (an != 3'(i) && n < 64) begin
        tick();
        n++;
      end
      sb_push($sformatf("%s_d%0d", nm, i), {28'd0, v[4*i +: 4]});
      sb_cmp({28'd0, seg});
    end
  endtask

  initial begin
    logic [31:0] d;
    int e0, rises, last, bcyc, n;
    bit gap_bad, prev, hit;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,        8'h1C, 32'h0,    5'h1F, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,        8'h14, 32'h0,    5'h1F, 1'b1};
    vecs[2]  = '{1'b1, 8'h00, 32'hFFFFFFEA, 8'h00, 32'h0,    5'h0A, 1'b1};
    vecs[3]  = '{1'b1, 8'h04, 32'hFFFFFFFE, 8'h04, 32'h0,    5'h0A, 1'b0};
    vecs[4]  = '{1'b1, 8'h04, 32'h1,        8'h08, 32'h0,    5'h0A, 1'b1};
    vecs[5]  = '{1'b1, 8'h18, 32'hABCD1234, 8'h18, 32'h1234, 5'h0A, 1'b1};
    vecs[6]  = '{1'b1, 8'h14, 32'h55,       8'h14, 32'h55,   5'h0A, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 32'h0,        8'h1C, 32'h1,    5'h0A, 1'b1};
    vecs[8]  = '{1'b1, 8'h1C, 32'hFFFFFFFE, 8'h1C, 32'h0,    5'h0A, 1'b1};
    vecs[9]  = '{1'b1, 8'h1C, 32'h1,        8'h1C, 32'h1,    5'h0A, 1'b1};
    vecs[10] = '{1'b1, 8'h20, 32'hFFFFFFFF, 8'h14, 32'h55,   5'h0A, 1'b1};
    vecs[11] = '{1'b1, 8'h18, 32'h0,        8'h18, 32'h0,    5'h0A, 1'b1};
    vecs[12] = '{1'b1, 8'h1C, 32'h0,        8'h1C, 32'h0,    5'h0A, 1'b1};
    vecs[13] = '{1'b1, 8'h08, 32'h12345678, 8'h0C, 32'h0,    5'h0A, 1'b1};
    vecs[14] = '{1'b1, 8'h00, 32'h1F,       8'h10, 32'h0,    5'h1F, 1'b1};

    for (int k = 0; k < NCH; k++) begin
      pv[k] = $urandom;
      probe[k*DW +: DW] = pv[k];
    end

    // reset defaults
    repeat (2) tick();
    chk("rst_clk_cpu", {31'd0, clk_cpu}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_view", {31'd0, view}, 32'd0);
    chk("rst_out0", {27'd0, out0}, 32'h1F);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_an", {29'd0, an}, 32'd0);
    rst = 1'b0;
    chk_digits("rst_disp", 32'h12345678);

    // register vectors
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].we) io_wr(vecs[i].wa, vecs[i].wd);
      else tick();
      sb_push($sformatf("vec%0d_rd", i), vecs[i].rexp);
      sb_push($sformatf("vec%0d_out0", i), {27'd0, vecs[i].o0});
      sb_push($sformatf("vec%0d_ready", i), {31'd0, vecs[i].rdy});
      io_rd(vecs[i].ra, d);
      sb_cmp(d);
      sb_cmp({27'd0, out0});
      sb_cmp({31'd0, ready});
    end
    io_addr = 8'hFF;
    tick();

    // single step: latency then two more presses
    e0 = edges;
    max_hi = 0;
    step = 1'b1;
    tick();
    tick();
    chk("lat_k1", {31'd0, clk_cpu}, 32'd0);
    tick();
    chk("lat_k2", {31'd0, clk_cpu}, 32'd0);
    tick();
    chk("lat_k3", {31'd0, clk_cpu}, 32'd1);
    step = 1'b0;
    tick();
    chk("lat_k4", {31'd0, clk_cpu}, 32'd0);
    repeat (6) tick();
    press_step();
    press_step();
    chk("step_edges", edges - e0, 32'd3);
    chk("step_width", max_hi, 32'd1);
    io_rd(8'h1C, d);
    chk("step_state", {30'd0, d[2:1]}, 32'd0);

    // burst of 5 with an ignored mid-burst press
    io_wr(8'h18, 32'd5);
    io_addr = 8'h1C;
    e0 = edges;
    max_hi = 0;
    rises = 0;
    last = 0;
    bcyc = 0;
    gap_bad = 1'b0;
    prev = 1'b0;
    step = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (t == 2) step = 1'b0;
      if (io_din[2:1] == 2'd2) bcyc++;
      if (bcyc == 2) step = 1'b1;
      if (bcyc == 5) step = 1'b0;
      if (clk_cpu && !prev) begin
        if (rises > 0 && t - last != 2) gap_bad = 1'b1;
        rises++;
        last = t;
      end
      prev = clk_cpu;
    end
    chk("burst_rises", rises, 32'd5);
    chk("burst_edges", edges - e0, 32'd5);
    chk("burst_gap", {31'd0, gap_bad}, 32'd0);
    chk("burst_len", bcyc, 32'd11);
    chk("burst_width", max_hi, 32'd1);
    chk("burst_state", {30'd0, io_din[2:1]}, 32'd0);
    io_wr(8'h18, 32'd0);

    // breakpoint at 0x10 while running
    io_wr(8'h14, 32'h10);
    pc_v = '0;
    pc_auto = 1'b1;
    e0 = edges;
    max_hi = 0;
    run = 1'b1;
    n = 0;
    while (!halted && n < 200) begin
      tick();
      n++;
    end
    chk("bp_timeout", {31'd0, halted}, 32'd1);
    repeat (3) tick();
    chk("bp_pc", pc_v, 32'h10);
    chk("bp_edges", edges - e0, 32'd4);
    io_rd(8'h1C, d);
    chk("bp_status", d, 32'hF);
    press_step();
    chk("halt_step_edges", edges - e0, 32'd5);
    chk("halt_step_pc", pc_v, 32'h14);
    io_rd(8'h1C, d);
    chk("halt_step_status", d, 32'hF);
    run = 1'b0;
    repeat (5) tick();
    chk("unhalt_led", {31'd0, halted}, 32'd0);
    io_rd(8'h1C, d);
    chk("unhalt_status", d, 32'h1);
    chk("bp_width", max_hi, 32'd1);
    pc_auto = 1'b0;
    io_wr(8'h1C, 32'd0);

    // viewer wrap
    valid = 1'b1;
    repeat (3) tick();
    valid = 1'b0;
    repeat (6) tick();
    chk("view_on", {31'd0, view}, 32'd1);
    chk("view_sel0", {27'd0, out0}, 32'd0);
    in_v = 5'b00010;
    repeat (8) tick();
    chk("prev_wrap", {27'd0, out0}, 32'd15);
    chk_digits("probe15", pv[15]);
    in_v = in_v ^ 5'b00001;
    repeat (8) tick();
    in_v = in_v ^ 5'b00001;
    repeat (8) tick();
    chk("next_wrap", {27'd0, out0}, 32'd1);
    in_v = in_v ^ 5'b00011;
    repeat (8) tick();
    chk("both_nochg", {27'd0, out0}, 32'd1);
    io_rd(8'h0C, d);
    chk("rd_in", d, {27'd0, in_v});
    chk_digits("probe1", pv[1]);

    // reset during a burst with remaining = 3
    io_wr(8'h18, 32'd5);
    e0 = edges;
    hit = 1'b0;
    step = 1'b1;
    for (int t = 0; t < 60 && !hit; t++) begin
      tick();
      if (t == 2) step = 1'b0;
      if (edges - e0 == 2) hit = 1'b1;
    end
    chk("rstmid_reach", {31'd0, hit}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_clk", {31'd0, clk_cpu}, 32'd0);
    chk("rstmid_view", {31'd0, view}, 32'd0);
    e0 = edges;
    repeat (3) tick();
    io_rd(8'h1C, d);
    chk("rstmid_state", d, 32'd0);
    io_rd(8'h18, d);
    chk("rstmid_burst_n", d, 32'd0);
    rst = 1'b0;
    io_addr = 8'hFF;
    repeat (12) tick();
    chk("rstmid_no_edges", edges - e0, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pdu_dbg.md
# pdu_dbg

Parametrised debug and peripheral unit for the pipelined CPU board build. It sits between the board I/O (switches, buttons, LEDs, scanned 7-segment display) and the CPU core, and generates `clk_cpu` in four modes: free-run, single-step, counted burst and PC breakpoint. It exposes an N-channel probe viewer with wrap-around selection, and memory-mapped I/O registers for program output, breakpoint and burst control.

## Interface
- `DW`, 32, data/probe/IO width; must be a multiple of 4. Display digit count is `DW/4`.
- `NCH`, 16, number of probe channels, 2..256. `SW = clog2(NCH)`.
- `CW`, 5, switch width, at least `SW` and at least 2.
- `SCAN_BITS`, 20, display refresh counter width.
- `clk  in  1`: system clock.
- `rst  in  1`: asynchronous, active-high reset.
- `run  in  1`: free-run level switch, raw.
- `step  in  1`: step pushbutton, raw.
- `valid  in  1`: view toggle button, raw.
- `in  in  CW`: switches. `in[0]` = next, `in[1]` = prev; any edge of either counts.
- `clk_cpu  out  1`: CPU clock.
- `pc  in  DW`: current fetch PC from the CPU.
- `io_addr  in  8`, `io_dout  in  DW`, `io_we  in  1`: CPU I/O write bus.
- `io_din  out  DW`: CPU I/O read data, combinational.
- `probe  in  NCH*DW`: flattened probe bus; channel k is `probe[k*DW +: DW]`.
- `out0  out  CW`: LED field.
- `ready  out  1`: LED.
- `halted  out  1`: breakpoint-hit LED.
- `view  out  1`: 0 = program output, 1 = probe view.
- `an  out  clog2(DW/4)`: digit select.
- `seg  out  4`: digit nibble.

## Operation
- **Input conditioning:** `run`, `step`, `valid` and `in` each pass through a 2-flop synchroniser. A third flop feeds edge detection.
  - `step_p`: rising edge of step.
  - `valid_p`: rising edge of valid.
  - `nx`, `pv`: any edge of `in[0]` and `in[1]` respectively.
- **Clock FSM states:**
  - IDLE
    - `clk_cpu` = 0.
    - On `step_p`: if `burst_n` = 0, issue one pulse (`clk_cpu` high for exactly one clk); otherwise load `remaining = burst_n` and go to BURST.
    - If synchronised `run` = 1, go to RUN. `run` has priority over `step_p`.
  - RUN
    - `clk_cpu` toggles every clk.
    - If synchronised `run` = 0 while `clk_cpu` = 0, go to IDLE. A high phase always completes.
  - BURST
    - `clk_cpu` toggles every clk; `remaining` decrements on each rising edge.
    - When `remaining` = 0 and `clk_cpu` = 0, go to IDLE.
  - HALT
    - `clk_cpu` = 0, `halted` = 1.
    - `step_p` issues a single pulse and the FSM stays in HALT.
    - When synchronised `run` = 0, go to IDLE and clear `halted`.
- **Breakpoint:**
  - Applies in RUN and BURST when `bp_en` = 1, `clk_cpu` = 0 and `pc == bp_addr`.
  - The rising edge is suppressed and the FSM goes to HALT.
  - The first rising edge after entering RUN or BURST skips the compare, so a resume does not re-hit the same PC.
- **I/O writes** (when `io_we` = 1):
  - 0x00: `out0_r <= io_dout[CW-1:0]`.
  - 0x04: `ready_r <= io_dout[0]`.
  - 0x08: `out1_r <= io_dout`.
  - 0x14: `bp_addr <= io_dout`, `bp_en <= 1`.
  - 0x18: `burst_n <= io_dout[15:0]`.
  - 0x1C: `bp_en <= io_dout[0]`.
  - Other addresses: ignored.
- **I/O reads** (zero-extended; all other addresses read 0):
  - 0x0C: `in`.
  - 0x10: `valid`.
  - 0x14: `bp_addr`.
  - 0x18: `burst_n`.
  - 0x1C: `{halted, state[1:0], bp_en}`, with state encoded IDLE=0, RUN=1, BURST=2, HALT=3.
- **Viewer:**
  - `valid_p` toggles `view`.
  - `nx` increments `sel` and wraps from NCH-1 to 0.
  - `pv` decrements `sel` and wraps from 0 to NCH-1.
  - `nx` and `pv` in the same cycle: no change.
  - `sel` is not cleared by stepping.
- **Display:**
  - `view` = 0: `out0 = out0_r`, `disp = out1_r`.
  - `view` = 1: `out0 = sel` (zero-extended), `disp = probe[sel]`.
  - `an = cnt[SCAN_BITS-1 -: clog2(DW/4)]`, where `cnt` is a free-running counter.
  - `seg = disp[4*an +: 4]`.

## Timing
- **Reset values:**
  - State IDLE, `clk_cpu` 0, `halted` 0, `view` 0, `sel` 0, `cnt` 0.
  - `out0_r` all ones, `ready` 1, `out1_r` 0x12345678 (truncated or zero-extended to DW).
  - `bp_en` 0, `bp_addr` 0, `burst_n` 0.
  - Synchroniser flops 0.
- Reset asserted mid-burst or in HALT forces IDLE immediately, with no further `clk_cpu` edges.
- **Step latency:** `step` high before clk edge k gives `clk_cpu` = 1 after edge k+3, and `clk_cpu` = 0 after edge k+4.
- **BURST with N:** exactly N `clk_cpu` rising edges, spaced 2 clk apart. Returns to IDLE 2N+1 clk after entry unless a breakpoint hits.
- **Breakpoint timing:** halt is decided in the cycle where `clk_cpu` = 0; no partial pulse is ever produced.
- **Register writes:** take effect the clk after `io_we`. Reads are same-cycle.
- A `burst_n` write during BURST does not alter `remaining`.

## Test plan
- **Reset defaults:** reset, then `view` = 0 → `out0` = 0x1F, `ready` = 1, digits cycle through 8,7,6,5,4,3,2,1 across `an` = 0..7, and read 0x1C = 0.
- **Single step:** `burst_n` = 0, three step presses → exactly 3 one-clk `clk_cpu` pulses, state remains IDLE.
- **Burst:** write 0x18 = 5, press step → exactly 5 `clk_cpu` rising edges, then state IDLE; a step press in mid-burst is ignored.
- **Breakpoint:** write 0x14 = 0x0000_0010, set `run` = 1, `pc` advancing by 4 per CPU edge from 0 → halt with `pc` = 0x10, `halted` = 1. With `run` still 1, step once → one pulse and still HALT. Drop `run` → IDLE, `halted` = 0.
- **Viewer wrap:** `view` = 1, NCH = 16, toggle prev once from `sel` = 0 → `sel` = 15, `seg` shows `probe[15]` nibbles. Toggle next twice → `sel` = 1. Toggle `in[0]` and `in[1]` in the same cycle → `sel` unchanged.
- **Reset mid-operation:** assert `rst` during BURST with `remaining` = 3 → `clk_cpu` = 0 immediately, state IDLE, `burst_n` = 0.
